// File: rtl/period_meter.sv
// ---------------------------------------------------------------------------
// period_meter
//
// Recovers the period and high time of a slow square wave, counted in cycles
// of the fast system clock. This is the receiving end of a clock divider:
// the divider turns a cycle count into a toggling signal, and this block
// turns the toggling signal back into a cycle count. It lives entirely in
// the clk domain; sig_in is synchronized internally.
//
// Ports
//   clk         in   1      system clock, all logic on posedge
//   rst         in   1      synchronous, active-high reset
//   sig_in      in   1      asynchronous square wave to measure
//   enable      in   1      1 = measure, 0 = idle
//   period      out  CNT_W  clk cycles between the last two rising edges
//   high_time   out  CNT_W  clk cycles sig_in was high in that period
//   meas_valid  out  1      one-cycle pulse when period/high_time update
//   timeout     out  1      level: no rising edge within TIMEOUT cycles
//   busy        out  1      1 while in the MEASURE state
//
// Handshake: meas_valid is a one-cycle, push-only strobe with no ready.
// period and high_time are valid in the cycle meas_valid is high and hold
// their value until the next strobe or reset.
// ---------------------------------------------------------------------------
module period_meter #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 100000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  // Synchronizer (s1, s2) plus one history flop (s3) for edge detection.
  logic s1_q, s2_q, s3_q;

  state_e           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [CNT_W-1:0] hi_cap_q,  hi_cap_d;
  logic             hi_seen_q, hi_seen_d;
  logic [CNT_W-1:0] period_q,  period_d;
  logic [CNT_W-1:0] high_q,    high_d;
  logic             valid_q,   valid_d;
  logic             timeout_q, timeout_d;

  logic rise, fall;

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_cap_d  = hi_cap_q;
    hi_seen_d = hi_seen_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;

    if (!enable) begin
      // Any partial measurement is thrown away; results and timeout hold.
      state_d   = ST_IDLE;
      cnt_d     = '0;
      hi_seen_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d   = '0;
          state_d = ST_ARM;
        end

        ST_ARM: begin
          cnt_d = '0;
          // The first rise only opens a measurement window; the count
          // starts at 1 so that the next rise sees the full period.
          if (rise) begin
            state_d   = ST_MEASURE;
            cnt_d     = ONE_C;
            hi_seen_d = 1'b0;
          end
        end

        ST_MEASURE: begin
          // rise is checked before the timeout limit so that a period of
          // exactly TIMEOUT cycles still produces a measurement.
          if (rise) begin
            period_d  = cnt_q;
            high_d    = hi_cap_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            cnt_d     = ONE_C;
            hi_seen_d = 1'b0;
          end else if (cnt_q >= TIMEOUT_C) begin
            timeout_d = 1'b1;
            state_d   = ST_ARM;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + ONE_C;
            // Only the first fall after a rise marks the end of high time.
            if (fall && !hi_seen_q) begin
              hi_cap_d  = cnt_q;
              hi_seen_d = 1'b1;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_cap_q  <= '0;
      hi_seen_q <= 1'b0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      s1_q      <= sig_in;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_cap_q  <= hi_cap_d;
      hi_seen_q <= hi_seen_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign meas_valid = valid_q;
  assign timeout    = timeout_q;
  assign busy       = (state_q == ST_MEASURE);

endmodule

// File: tb/tb_period_meter.sv
// ---------------------------------------------------------------------------
// tb_period_meter
//
// Directed bench for period_meter with CNT_W=16, TIMEOUT=64. Each driven
// wave period that will be closed by a later rising edge pushes its
// expected {period, high_time} onto exp_q; every meas_valid pulse pops and
// compares. Inputs change 1 time unit after posedge; outputs are sampled
// at the negedge.
// ---------------------------------------------------------------------------
module tb_period_meter;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 64;
  localparam int W       = 2 * CNT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic sig_in;
  logic enable;

  always #5 clk = ~clk;

  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             timeout;
  logic             busy;

  period_meter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_in),
    .enable     (enable),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .timeout    (timeout),
    .busy       (busy)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0]     exp_q[$];
  logic [W-1:0]     exp_item;
  logic [CNT_W-1:0] last_period;
  logic [CNT_W-1:0] last_high;
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [CNT_W-1:0] obs,
                       input logic [CNT_W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called once per clk cycle at the negedge.
  task automatic sample();
    if (meas_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL unexpected_meas_valid observed period=%0d high=%0d expected none",
               period, high_time);
      end else begin
        exp_item = exp_q.pop_front();
        check("meas_period", period, exp_item[W-1:CNT_W]);
        check("meas_high", high_time, exp_item[CNT_W-1:0]);
        check("meas_timeout_clear", CNT_W'(timeout), '0);
      end
    end
  endtask

  // Advance n cycles; returns 1 time unit after a posedge.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- driver tasks ----------------
  // One wave period: hi cycles high then lo cycles low. push=1 when a
  // later rise will close this period into a measurement.
  task automatic drive_period(input int hi, input int lo, input bit push);
    if (push) begin
      exp_q.push_back({CNT_W'(hi + lo), CNT_W'(hi)});
      last_period = CNT_W'(hi + lo);
      last_high   = CNT_W'(hi);
    end
    sig_in = 1'b1;
    tick(hi);
    sig_in = 1'b0;
    tick(lo);
  endtask

  task automatic start_enable();
    sig_in = 1'b0;
    enable = 1'b1;
    tick(4);
    check("armed_busy", CNT_W'(busy), '0);
  endtask

  task automatic finish_phase(input string tag);
    tick(4);
    enable = 1'b0;
    tick(3);
    check({tag, "_queue_empty"}, CNT_W'(exp_q.size()), '0);
    check({tag, "_idle_busy"}, CNT_W'(busy), '0);
    check({tag, "_held_period"}, period, last_period);
    check({tag, "_held_high"}, high_time, last_high);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hi;
    int lo;
    rst         = 1'b1;
    sig_in      = 1'b0;
    enable      = 1'b0;
    last_period = '0;
    last_high   = '0;
    @(posedge clk);
    #1;
    tick(3);
    check("rst_period", period, '0);
    check("rst_high", high_time, '0);
    check("rst_valid", CNT_W'(meas_valid), '0);
    check("rst_timeout", CNT_W'(timeout), '0);
    check("rst_busy", CNT_W'(busy), '0);
    rst = 1'b0;
    tick(2);

    // Period 10, high 4.
    start_enable();
    drive_period(4, 6, 1);
    check("p1_busy", CNT_W'(busy), 16'd1);
    drive_period(4, 6, 1);
    drive_period(4, 6, 1);
    drive_period(4, 6, 0);
    finish_phase("p1");

    // Divider with constantNumber=5: toggles every 5 cycles.
    start_enable();
    for (int i = 0; i < 3; i++) drive_period(5, 5, 1);
    drive_period(5, 5, 0);
    finish_phase("div5");

    // Random legal waves, each level held at least 2 cycles.
    start_enable();
    for (int i = 0; i < 6; i++) begin
      hi = $urandom_range(2, 20);
      lo = $urandom_range(2, 20);
      drive_period(hi, lo, 1);
    end
    drive_period(3, 6, 0);
    finish_phase("rand");

    // Timeout: one rise then low. The rise reaches the edge detector two
    // cycles after sig_in goes high; the count hits 64 one edge later than
    // 64, so timeout rises after the 67th edge.
    start_enable();
    sig_in = 1'b1;
    tick(4);
    sig_in = 1'b0;
    tick(62);
    check("to_not_yet", CNT_W'(timeout), '0);
    check("to_busy_before", CNT_W'(busy), 16'd1);
    tick(1);
    check("to_set", CNT_W'(timeout), 16'd1);
    check("to_busy_after", CNT_W'(busy), '0);
    check("to_period_kept", period, last_period);
    check("to_high_kept", high_time, last_high);
    tick(3);
    drive_period(5, 5, 1);
    check("to_still_set", CNT_W'(timeout), 16'd1);
    drive_period(5, 5, 0);
    check("to_cleared", CNT_W'(timeout), '0);
    finish_phase("to");

    // Period exactly TIMEOUT: the rise wins over the limit.
    start_enable();
    drive_period(30, 34, 1);
    drive_period(4, 6, 0);
    check("p64_timeout", CNT_W'(timeout), '0);
    finish_phase("p64");

    // Reset in the middle of a period.
    start_enable();
    drive_period(6, 6, 1);
    sig_in = 1'b1;
    tick(6);
    sig_in = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    last_period = '0;
    last_high   = '0;
    check("mid_rst_period", period, '0);
    check("mid_rst_high", high_time, '0);
    check("mid_rst_valid", CNT_W'(meas_valid), '0);
    check("mid_rst_timeout", CNT_W'(timeout), '0);
    check("mid_rst_busy", CNT_W'(busy), '0);
    tick(3);
    drive_period(5, 5, 1);
    drive_period(5, 5, 0);
    finish_phase("rst");

    // Enable dropped while sig_in is high; the stale high level must not
    // count as an edge when enable returns.
    start_enable();
    drive_period(5, 5, 1);
    drive_period(5, 5, 1);
    sig_in = 1'b1;
    tick(5);
    check("en_busy_before", CNT_W'(busy), 16'd1);
    enable = 1'b0;
    tick(10);
    check("en_idle_busy", CNT_W'(busy), '0);
    check("en_idle_period", period, last_period);
    check("en_idle_high", high_time, last_high);
    tick(10);
    enable = 1'b1;
    tick(5);
    check("en_no_edge", CNT_W'(busy), '0);
    sig_in = 1'b0;
    tick(5);
    drive_period(7, 3, 1);
    drive_period(7, 3, 0);
    finish_phase("en");

    check("final_queue_empty", CNT_W'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
